// File: rtl/bcd_serial_adder_n.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSB digit first,
// with start/done handshake, nines-complement subtract and sticky invalid-digit flag.
module bcd_serial_adder_n #(
   parameter int DIGITS = 4
) (
   input  logic                  Clk_in,
   input  logic                  Rst_in,
   input  logic                  Start_in,
   input  logic                  Sub_in,
   input  logic [4*DIGITS-1:0]   X_in,
   input  logic [4*DIGITS-1:0]   Y_in,
   input  logic                  C_in,
   output logic                  Busy_out,
   output logic                  Done_out,
   output logic [4*DIGITS-1:0]   Z_out,
   output logic                  C_out,
   output logic                  Err_out
);

   localparam int W     = 4 * DIGITS;
   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   dig_cnt;
   logic [W-1:0]       x_sh, y_sh, z_acc;
   logic               sub_q, carry_q, err_acc;

   logic               accept, last_dig;
   logic [3:0]         x_dig, y_dig, y_eff, dig_out;
   logic [4:0]         sum;
   logic               carry_nxt, dig_bad;
   logic [W+3:0]       z_ext;
   logic [W-1:0]       z_new;

   // Busy_out is low in DONE, so a back-to-back request is taken there too.
   assign accept   = Start_in && (state != S_RUN);
   assign last_dig = (dig_cnt == CNT_W'(DIGITS - 1));

   // Single-digit BCD cell, reused for every digit position.
   always_comb begin
      x_dig     = x_sh[3:0];
      y_dig     = y_sh[3:0];
      y_eff     = sub_q ? (4'd9 - y_dig) : y_dig;
      sum       = {1'b0, x_dig} + {1'b0, y_eff} + {4'b0, carry_q};
      dig_out   = sum[3:0];
      carry_nxt = 1'b0;
      if (sum > 5'd9) begin
         dig_out   = 4'(sum + 5'd6);
         carry_nxt = 1'b1;
      end
      dig_bad   = (x_dig > 4'd9) || (y_dig > 4'd9);
      // New digit enters at the top; after DIGITS shifts digit 0 sits in [3:0].
      z_ext     = {dig_out, z_acc} >> 4;
      z_new     = z_ext[W-1:0];
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge Clk_in or posedge Rst_in) begin
      if (Rst_in) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: default assignment first so no path through the case leaves state_nxt
   // unassigned, which would infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (Start_in) state_nxt = S_RUN;
         S_RUN:   if (last_dig) state_nxt = S_DONE;
         S_DONE:  state_nxt = Start_in ? S_RUN : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      Busy_out = (state == S_RUN);
      Done_out = (state == S_DONE);
   end

   always_ff @(posedge Clk_in or posedge Rst_in) begin
      if (Rst_in) begin
         dig_cnt <= '0;
         x_sh    <= '0;
         y_sh    <= '0;
         z_acc   <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         err_acc <= 1'b0;
         Z_out   <= '0;
         C_out   <= 1'b0;
         Err_out <= 1'b0;
      end else if (accept) begin
         dig_cnt <= '0;
         x_sh    <= X_in;
         y_sh    <= Y_in;
         sub_q   <= Sub_in;
         carry_q <= Sub_in | C_in;
         err_acc <= 1'b0;
      end else if (state == S_RUN) begin
         dig_cnt <= dig_cnt + CNT_W'(1);
         x_sh    <= x_sh >> 4;
         y_sh    <= y_sh >> 4;
         z_acc   <= z_new;
         carry_q <= carry_nxt;
         err_acc <= err_acc | dig_bad;
         // Results are published only on completion; they hold through the next run.
         if (last_dig) begin
            Z_out   <= z_new;
            C_out   <= carry_nxt;
            Err_out <= err_acc | dig_bad;
         end
      end
   end

endmodule

// File: tb/tb_bcd_serial_adder_n.sv
// Directed self-checking bench for bcd_serial_adder_n with DIGITS=4.
module tb_bcd_serial_adder_n;

   logic        clk, rst, start, sub, c_in;
   logic [15:0] x, y;
   logic        busy, done, c_out, err;
   logic [15:0] z;

   int checks   = 0;
   int failures = 0;

   bcd_serial_adder_n #(.DIGITS(4)) dut (
      .Clk_in   (clk),
      .Rst_in   (rst),
      .Start_in (start),
      .Sub_in   (sub),
      .X_in     (x),
      .Y_in     (y),
      .C_in     (c_in),
      .Busy_out (busy),
      .Done_out (done),
      .Z_out    (z),
      .C_out    (c_out),
      .Err_out  (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Drive one request from a negedge and wait (bounded) for Done_out.
   // lat = negedges after the accepting edge until Done_out is seen.
   task automatic run_op(input logic s, input logic [15:0] xv, input logic [15:0] yv,
                         input logic cv, output int lat, output int busy_cnt);
      @(negedge clk);
      start = 1'b1; sub = s; x = xv; y = yv; c_in = cv;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; sub = 1'b0; x = '0; y = '0; c_in = 1'b0;
      repeat (2) @(negedge clk);
      if ({busy, done, z, c_out, err} !== 20'h0) begin
         $display("FAIL reset_hold: got busy=%b done=%b z=%h c=%b err=%b, want all 0",
                  busy, done, z, c_out, err);
         failures++;
      end
      checks++;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      if ({busy, done, z, c_out, err} !== 20'h0) begin
         $display("FAIL reset_release: got busy=%b done=%b z=%h c=%b err=%b, want all 0",
                  busy, done, z, c_out, err);
         failures++;
      end
      checks++;
   endtask

   task automatic test_add();
      int lat, bc;
      run_op(1'b0, 16'h1234, 16'h5678, 1'b0, lat, bc);
      if (lat !== 5) begin
         $display("FAIL add_latency: got %0d cycles, want 5", lat); failures++;
      end
      checks++;
      if (bc !== 4) begin
         $display("FAIL add_busy_cycles: got %0d, want 4", bc); failures++;
      end
      checks++;
      if ({z, c_out, err} !== {16'h6912, 1'b0, 1'b0}) begin
         $display("FAIL add_1234_5678: got z=%h c=%b err=%b, want z=6912 c=0 err=0", z, c_out, err);
         failures++;
      end
      checks++;
      @(negedge clk);
      if (done !== 1'b0) begin
         $display("FAIL done_one_cycle: got done=%b after pulse, want 0", done); failures++;
      end
      checks++;

      run_op(1'b0, 16'h9999, 16'h0001, 1'b0, lat, bc);
      if ({z, c_out, err} !== {16'h0000, 1'b1, 1'b0}) begin
         $display("FAIL add_9999_0001: got z=%h c=%b err=%b, want z=0000 c=1 err=0", z, c_out, err);
         failures++;
      end
      checks++;

      run_op(1'b0, 16'h0999, 16'h0000, 1'b1, lat, bc);
      if ({z, c_out, err} !== {16'h1000, 1'b0, 1'b0}) begin
         $display("FAIL add_0999_cin: got z=%h c=%b err=%b, want z=1000 c=0 err=0", z, c_out, err);
         failures++;
      end
      checks++;
   endtask

   task automatic test_sub();
      int lat, bc;
      // c_in=1 in sub mode must be ignored
      run_op(1'b1, 16'h5000, 16'h1234, 1'b1, lat, bc);
      if ({z, c_out, err} !== {16'h3766, 1'b1, 1'b0}) begin
         $display("FAIL sub_5000_1234: got z=%h c=%b err=%b, want z=3766 c=1 err=0", z, c_out, err);
         failures++;
      end
      checks++;

      run_op(1'b1, 16'h0001, 16'h0002, 1'b0, lat, bc);
      if ({z, c_out, err} !== {16'h9999, 1'b0, 1'b0}) begin
         $display("FAIL sub_0001_0002: got z=%h c=%b err=%b, want z=9999 c=0 err=0", z, c_out, err);
         failures++;
      end
      checks++;

      run_op(1'b1, 16'h4321, 16'h4321, 1'b0, lat, bc);
      if ({z, c_out, err} !== {16'h0000, 1'b1, 1'b0}) begin
         $display("FAIL sub_equal: got z=%h c=%b err=%b, want z=0000 c=1 err=0", z, c_out, err);
         failures++;
      end
      checks++;
   endtask

   task automatic test_invalid();
      int lat, bc;
      run_op(1'b0, 16'h000A, 16'h0000, 1'b0, lat, bc);
      if ({z, c_out, err} !== {16'h0010, 1'b0, 1'b1}) begin
         $display("FAIL invalid_000A: got z=%h c=%b err=%b, want z=0010 c=0 err=1", z, c_out, err);
         failures++;
      end
      checks++;

      // invalid digit in Y, subtract mode: 0-(9-0xB mod 16)... only err is of interest
      run_op(1'b1, 16'h0000, 16'h0B00, 1'b0, lat, bc);
      if (err !== 1'b1) begin
         $display("FAIL invalid_y_sub: got err=%b, want 1", err); failures++;
      end
      checks++;

      run_op(1'b0, 16'h0001, 16'h0001, 1'b0, lat, bc);
      if ({z, c_out, err} !== {16'h0002, 1'b0, 1'b0}) begin
         $display("FAIL err_clears: got z=%h c=%b err=%b, want z=0002 c=0 err=0", z, c_out, err);
         failures++;
      end
      checks++;
   endtask

   task automatic test_handshake();
      int z_bad = 0;
      int extra = 0;
      // Z_out currently 0002 from the previous operation.
      @(negedge clk);
      start = 1'b1; sub = 1'b0; x = 16'h1234; y = 16'h5678; c_in = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (z !== 16'h0002) z_bad++;
         if (i < 4) begin
            x = 16'h9999 - 16'(i);
            y = 16'h1111 * 16'(i);
            sub = 1'b1;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      if (z_bad !== 0) begin
         $display("FAIL z_stable_in_run: got %0d changed samples, want 0", z_bad); failures++;
      end
      checks++;
      @(negedge clk);
      if ({done, z, c_out, err} !== {1'b1, 16'h6912, 1'b0, 1'b0}) begin
         $display("FAIL held_start: got done=%b z=%h c=%b err=%b, want done=1 z=6912 c=0 err=0",
                  done, z, c_out, err);
         failures++;
      end
      checks++;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (busy || done) extra++;
      end
      if (extra !== 0) begin
         $display("FAIL held_start_single_op: got %0d busy/done samples, want 0", extra); failures++;
      end
      checks++;
   endtask

   task automatic test_back_to_back();
      int lat, bc;
      run_op(1'b0, 16'h1234, 16'h5678, 1'b0, lat, bc);
      // Now in the DONE cycle: request the next operation here.
      start = 1'b1; sub = 1'b1; x = 16'h5000; y = 16'h1234; c_in = 1'b0;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (lat !== 5) begin
         $display("FAIL b2b_latency: got %0d cycles, want 5", lat); failures++;
      end
      checks++;
      if ({z, c_out, err} !== {16'h3766, 1'b1, 1'b0}) begin
         $display("FAIL b2b_result: got z=%h c=%b err=%b, want z=3766 c=1 err=0", z, c_out, err);
         failures++;
      end
      checks++;
   endtask

   task automatic test_reset_mid();
      int lat, bc;
      int seen = 0;
      @(negedge clk);
      start = 1'b1; sub = 1'b0; x = 16'h1234; y = 16'h5678; c_in = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      if ({busy, done, z, c_out, err} !== 20'h0) begin
         $display("FAIL async_reset_mid: got busy=%b done=%b z=%h c=%b err=%b, want all 0",
                  busy, done, z, c_out, err);
         failures++;
      end
      checks++;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (busy || done || z !== 16'h0) seen++;
      end
      if (seen !== 0) begin
         $display("FAIL reset_discards_op: got %0d activity samples, want 0", seen); failures++;
      end
      checks++;
      run_op(1'b0, 16'h1234, 16'h5678, 1'b0, lat, bc);
      if (lat !== 5 || {z, c_out, err} !== {16'h6912, 1'b0, 1'b0}) begin
         $display("FAIL after_reset_op: got lat=%0d z=%h c=%b err=%b, want lat=5 z=6912 c=0 err=0",
                  lat, z, c_out, err);
         failures++;
      end
      checks++;
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_invalid();
      test_handshake();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
